pipe_hazard_sched: RTL and testbench
====================================

// Module: pipe_hazard_sched
// PURPOSE
//  Central stall/flush scheduler for the five-stage MIPS pipeline. It drives the enable/flush pins
//  of the F/D, D/E, E/M and M/W pipeline registers and the PC.
//  It owns the MDU busy sequencer (multi-cycle mult/div countdown) and merges data-hazard stalls,
//  HI/LO structural stalls and the CP0 exception/interrupt request (Req) into one control set.
// PARAMETERS
//  MULT_CYC  5   busy cycles after a mult/multu start
//  DIV_CYC   10  busy cycles after a div/divu start
//  CNT_W     4   width of the busy down-counter; must satisfy 2**CNT_W > max(MULT_CYC,DIV_CYC)
// PORTS
//  clk           in   1  clock
//  reset         in   1  synchronous, active-high reset
//  D_stall_data  in   1  Tuse/Tnew data hazard detected for the instr in D (combinational, external)
//  D_is_md       in   1  instr in D reads/writes HI/LO or starts the MDU (mult/div/mf*/mt*)
//  E_md_start    in   1  mult/div instr in E is starting this cycle
//  E_md_is_div   in   1  qualifies E_md_start: 1 = div/divu, 0 = mult/multu
//  Req           in   1  CP0 exception/interrupt taken at M this cycle
//  pc_en         out  1  PC update enable
//  fd_en         out  1  F/D register enable
//  fd_flush      out  1  F/D register flush
//  de_en         out  1  D/E register enable
//  de_flush      out  1  D/E register flush (bubble insert)
//  em_en         out  1  E/M register enable
//  em_flush      out  1  E/M register flush
//  mw_en         out  1  M/W register enable
//  mw_flush      out  1  M/W register flush
//  md_start_ok   out  1  gated MDU start = E_md_start & ~Req
//  md_busy       out  1  MDU computing (counter != 0)
//  md_err        out  1  sticky: E_md_start seen while md_busy
//  stall_cnt     out  32 perf counter of stalled cycles
// BEHAVIOUR
//  Busy sequencer: state IDLE (cnt==0) / BUSY (cnt!=0).
//   IDLE & md_start_ok -> cnt <= E_md_is_div ? DIV_CYC : MULT_CYC; go to BUSY.
//   BUSY: cnt <= cnt-1 each cycle; reaching 0 returns to IDLE. A start at cycle t gives
//   md_busy=1 on cycles t+1..t+CYC.
//  Req does not cancel an in-flight MDU op; cnt keeps counting. Only the start in E is
//   suppressed (md_start_ok=0), because that instr is a victim of the flush.
//  BUSY & md_start_ok: illegal; cnt reloads with the new CYC and md_err <= 1 (sticky until reset).
//  stall = D_stall_data | (D_is_md & (md_busy | E_md_start)).
//  Output priority (combinational, zero latency), evaluated top to bottom:
//   1. Req: pc_en=1 (PC loads handler); all *_flush=1; all *_en=1.
//      Req overrides stall; stall_cnt does not increment.
//   2. stall: pc_en=0, fd_en=0, de_flush=1, de_en=1, em_en=1, mw_en=1; other flushes 0;
//      stall_cnt <= stall_cnt+1, wrapping at 2**32-1 -> 0.
//   3. else: all *_en=1, all *_flush=0.
//  Reset (on the clk edge with reset=1): cnt=0, md_busy=0, md_err=0, stall_cnt=0.
//   While reset is high, outputs take the priority-3 values regardless of inputs,
//   md_start_ok=0, and no counter advances.
//  Reset mid-operation aborts the busy countdown immediately: md_busy=0 on the next cycle.
//  Simultaneous Req & E_md_start & D_is_md: Req wins, no start, no stall count.
// STRUCTURE
//  Shared package/header: MULT_CYC, DIV_CYC, and the stage-control bundle field order
//  {pc_en,fd_en,fd_flush,de_en,de_flush,em_en,em_flush,mw_en,mw_flush}.
//  Sub-module md_busy_seq: the counter, md_busy and md_err.
//  The top level holds the priority mux and stall_cnt.
// TESTING
//  1. mult start (E_md_start=1, is_div=0) at cycle 10 -> md_busy=1 on cycles 11..15, 0 on 16.
//  2. div start at cycle 10, D_is_md=1 held -> stall on cycles 10..20: pc_en=0, de_flush=1;
//     released on 21; stall_cnt=11.
//  3. Req=1 with E_md_start=1 -> md_start_ok=0, all flushes=1, pc_en=1, md_busy stays 0.
//  4. Req at cycle 12 during a div started at 10 -> md_busy stays high through cycle 20;
//     flushes asserted only on cycle 12.
//  5. E_md_start while md_busy -> md_err=1, held after busy ends; reset clears it to 0.
//  6. D_stall_data=1 and reset=1 for 3 cycles mid-div -> after release: cnt=0, stall_cnt=0,
//     outputs at priority-3 values.

Source files
------------

// File: rtl/pipe_hazard_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_sched_pkg
// Brief   : Shared constants and stage-control bundle for the hazard scheduler.
// Revision: 1.0
// ============================================================================
package pipe_hazard_sched_pkg;

    localparam int MD_MULT_CYC = 5;
    localparam int MD_DIV_CYC  = 10;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic fd_flush;
        logic de_en;
        logic de_flush;
        logic em_en;
        logic em_flush;
        logic mw_en;
        logic mw_flush;
    } stage_ctrl_t;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam stage_ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_sched_md_busy_seq.sv
`default_nettype none
// ============================================================================
// Module  : md_busy_seq
// Brief   : MDU busy down-counter with sticky start-while-busy error flag.
// Revision: 1.0
// ============================================================================
module md_busy_seq
    import pipe_hazard_sched_pkg::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC,
    parameter int DIV_CYC  = MD_DIV_CYC,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy,
    output logic o_err
);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_load;
    logic               r_err;
    logic               w_err_nxt;

    assign w_load = i_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // A start while busy is illegal: the newer op's latency wins and the error sticks.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_nxt = r_err;
        case (r_state)
            MD_IDLE: begin
                if (i_start) w_cnt_nxt = w_load;
            end
            MD_BUSY: begin
                if (i_start) begin
                    w_cnt_nxt = w_load;
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_cnt_nxt = '0;
        endcase
        w_state_nxt = (w_cnt_nxt != '0) ? MD_BUSY : MD_IDLE;
    end

    always_comb begin
        o_busy = (r_state == MD_BUSY);
        o_err  = r_err;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_sched
// Brief   : Pipeline stall/flush scheduler merging data, HI/LO and CP0 hazards.
// Revision: 1.0
// ============================================================================
module pipe_hazard_sched
    import pipe_hazard_sched_pkg::*;
#(
    parameter int MULT_CYC = MD_MULT_CYC,
    parameter int DIV_CYC  = MD_DIV_CYC,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall_data,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    input  logic        Req,
    output logic        pc_en,
    output logic        fd_en,
    output logic        fd_flush,
    output logic        de_en,
    output logic        de_flush,
    output logic        em_en,
    output logic        em_flush,
    output logic        mw_en,
    output logic        mw_flush,
    output logic        md_start_ok,
    output logic        md_busy,
    output logic        md_err,
    output logic [31:0] stall_cnt
);

    stage_ctrl_t w_ctrl;
    logic        w_md_start_ok;
    logic        w_md_busy;
    logic        w_stall;
    logic [31:0] r_stall_cnt;

    // The E-stage start is a flush victim when Req fires, so it must not launch.
    assign w_md_start_ok = E_md_start & ~Req & ~reset;
    assign w_stall       = D_stall_data | (D_is_md & (w_md_busy | E_md_start));

    md_busy_seq #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_seq (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_md_start_ok),
        .i_is_div (E_md_is_div),
        .o_busy   (w_md_busy),
        .o_err    (md_err)
    );

    always_comb begin
        w_ctrl = CTRL_RUN;
        if (!reset) begin
            if (Req)          w_ctrl = CTRL_FLUSH;
            else if (w_stall) w_ctrl = CTRL_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)               r_stall_cnt <= '0;
        else if (!Req && w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign {pc_en, fd_en, fd_flush, de_en, de_flush,
            em_en, em_flush, mw_en, mw_flush} = w_ctrl;
    assign md_start_ok = w_md_start_ok;
    assign md_busy     = w_md_busy;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_sched
// Brief   : Directed scoreboard bench for pipe_hazard_sched.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_sched;

    localparam logic [8:0] RUN = 9'b110101010;
    localparam logic [8:0] STL = 9'b000111010;
    localparam logic [8:0] FLS = 9'b111111111;

    logic        clk = 1'b0;
    logic        reset, D_stall_data, D_is_md, E_md_start, E_md_is_div, Req;
    logic        pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush;
    logic        md_start_ok, md_busy, md_err;
    logic [31:0] stall_cnt;
    logic [43:0] act;

    typedef struct {
        string       nm;
        logic [43:0] exp;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_sched dut (
        .clk          (clk),
        .reset        (reset),
        .D_stall_data (D_stall_data),
        .D_is_md      (D_is_md),
        .E_md_start   (E_md_start),
        .E_md_is_div  (E_md_is_div),
        .Req          (Req),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .fd_flush     (fd_flush),
        .de_en        (de_en),
        .de_flush     (de_flush),
        .em_en        (em_en),
        .em_flush     (em_flush),
        .mw_en        (mw_en),
        .mw_flush     (mw_flush),
        .md_start_ok  (md_start_ok),
        .md_busy      (md_busy),
        .md_err       (md_err),
        .stall_cnt    (stall_cnt)
    );

    assign act = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en, mw_flush,
                  md_start_ok, md_busy, md_err, stall_cnt};

    task automatic step(input string nm, input logic sd, input logic md, input logic st,
                        input logic dv, input logic rq, input logic rs,
                        input logic [8:0] ec, input logic eok, input logic eb,
                        input logic ee, input logic [31:0] esc);
        exp_t e;
        @(posedge clk);
        #1;
        D_stall_data = sd;
        D_is_md      = md;
        E_md_start   = st;
        E_md_is_div  = dv;
        Req          = rq;
        reset        = rs;
        e.nm  = nm;
        e.exp = {ec, eok, eb, ee, esc};
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got ctrl=%b ok=%b busy=%b err=%b cnt=%0d want ctrl=%b ok=%b busy=%b err=%b cnt=%0d",
                             e.nm, act[43:35], act[34], act[33], act[32], act[31:0],
                             e.exp[43:35], e.exp[34], e.exp[33], e.exp[32], e.exp[31:0]);
                end
            end
        end
    end

    initial begin : driver
        reset = 1'b1; D_stall_data = 1'b0; D_is_md = 1'b0;
        E_md_start = 1'b0; E_md_is_div = 1'b0; Req = 1'b0;

        // reset dominates every input
        step("rst0",      0,0,0,0,0,1, RUN,0,0,0,0);
        step("rst_ovr",   1,1,1,1,1,1, RUN,0,0,0,0);
        step("rst_hold",  1,1,1,0,0,1, RUN,0,0,0,0);
        step("idle",      0,0,0,0,0,0, RUN,0,0,0,0);

        // mult: busy for 5 cycles after start
        step("mul_start", 0,0,1,0,0,0, RUN,1,0,0,0);
        for (int i = 0; i < 5; i++) step("mul_busy", 0,0,0,0,0,0, RUN,0,1,0,0);
        step("mul_done",  0,0,0,0,0,0, RUN,0,0,0,0);

        // div with HI/LO consumer waiting in D: 11 stalled cycles
        step("div_start_stall", 0,1,1,1,0,0, STL,1,0,0,0);
        for (int i = 1; i <= 10; i++) step("div_stall", 0,1,0,0,0,0, STL,0,1,0,i);
        step("div_release", 0,1,0,0,0,0, RUN,0,0,0,11);

        // Req with a start and HI/LO user: flush wins, no start, no count
        step("req_start", 0,1,1,0,1,0, FLS,0,0,0,11);
        step("req_after", 0,0,0,0,0,0, RUN,0,0,0,11);

        // Req during an in-flight div does not cancel it
        step("div2_start", 0,0,1,1,0,0, RUN,1,0,0,11);
        step("div2_busy",  0,0,0,0,0,0, RUN,0,1,0,11);
        step("div2_req",   0,0,0,0,1,0, FLS,0,1,0,11);
        for (int i = 0; i < 8; i++) step("div2_busy", 0,0,0,0,0,0, RUN,0,1,0,11);
        step("div2_done",  0,0,0,0,0,0, RUN,0,0,0,11);

        step("data_stall", 1,0,0,0,0,0, STL,0,0,0,11);
        step("data_rel",   0,0,0,0,0,0, RUN,0,0,0,12);

        // start while busy: reload and sticky error
        step("mul3_start",  0,0,1,0,0,0, RUN,1,0,0,12);
        step("mul_restart", 0,0,1,0,0,0, RUN,1,1,0,12);
        for (int i = 0; i < 5; i++) step("err_busy", 0,0,0,0,0,0, RUN,0,1,1,12);
        step("err_sticky", 0,0,0,0,0,0, RUN,0,0,1,12);
        step("err_rst",    0,0,0,0,0,1, RUN,0,0,1,12);
        step("err_clr",    0,0,0,0,0,0, RUN,0,0,0,0);

        // reset with data stall in the middle of a div
        step("div3_start", 0,0,1,1,0,0, RUN,1,0,0,0);
        step("div3_busy",  0,0,0,0,0,0, RUN,0,1,0,0);
        step("div3_busy",  0,0,0,0,0,0, RUN,0,1,0,0);
        step("rst_mid0",   1,0,0,0,0,1, RUN,0,1,0,0);
        step("rst_mid1",   1,0,0,0,0,1, RUN,0,0,0,0);
        step("rst_mid2",   1,0,0,0,0,1, RUN,0,0,0,0);
        step("post_rst",   0,0,0,0,0,0, RUN,0,0,0,0);
        step("stall_post", 1,0,0,0,0,0, STL,0,0,0,0);
        step("cnt_post",   0,0,0,0,0,0, RUN,0,0,0,1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d unchecked entries want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
